// File: rtl/edge_detect_multi_if.sv
// Channel bundle for edge_detect_multi: raw inputs and controls in, filtered
// level, edge pulse/direction and sticky flags out.
interface edge_detect_multi_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   sig;
  logic [2*NUM_CH-1:0] mode;
  logic [NUM_CH-1:0]   clr_sticky;
  logic [NUM_CH-1:0]   level;
  logic [NUM_CH-1:0]   pulse;
  logic [NUM_CH-1:0]   dir;
  logic [NUM_CH-1:0]   sticky;

  modport master (
    output sig, mode, clr_sticky,
    input  level, pulse, dir, sticky
  );

  modport slave (
    input  sig, mode, clr_sticky,
    output level, pulse, dir, sticky
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Per-channel synchroniser, debounce filter, mode-qualified edge pulse and sticky flag.
// Level updates SYNC_STAGES+max(DB_CYCLES,1) edges after a held input change; no backpressure.
module edge_detect_multi #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000
) (
  input logic                clk,
  input logic                rst,
  edge_detect_multi_if.slave bus
);

  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

  logic [NUM_CH-1:0] s;
  logic [NUM_CH-1:0] level_q;
  logic [NUM_CH-1:0] level_d;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] dir;
  logic [NUM_CH-1:0] sticky_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;
    logic                   stk;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig[i]};
      end
    end

    assign s[i] = sync_q[SYNC_STAGES-1];

    if (DB_CYCLES < 2) begin : g_nodb
      always_ff @(posedge clk) begin
        if (rst) begin
          lvl <= 1'b0;
        end else begin
          lvl <= s[i];
        end
      end
    end else begin : g_db
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
      logic [CNT_W-1:0] cnt;

      // Any sample agreeing with the current level restarts the stability count.
      always_ff @(posedge clk) begin
        if (rst) begin
          lvl <= 1'b0;
          cnt <= '0;
        end else if (s[i] == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          lvl <= s[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lvl_d <= 1'b0;
      end else begin
        lvl_d <= lvl;
      end
    end

    assign level_q[i] = lvl;
    assign level_d[i] = lvl_d;
    assign rise[i]    = lvl & ~lvl_d;
    assign fall[i]    = ~lvl & lvl_d;
    // Mode gates only the pulse; a disabled edge is dropped, never deferred.
    assign pulse[i]   = (rise[i] & bus.mode[2*i]) | (fall[i] & bus.mode[2*i+1]);
    assign dir[i]     = rise[i] & pulse[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        stk <= 1'b0;
      end else if (pulse[i]) begin
        stk <= 1'b1;
      end else if (bus.clr_sticky[i]) begin
        stk <= 1'b0;
      end
    end

    assign sticky_q[i] = stk;
  end

  assign bus.level  = level_q;
  assign bus.pulse  = pulse;
  assign bus.dir    = dir;
  assign bus.sticky = sticky_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi with NUM_CH=4, SYNC_STAGES=2, DB_CYCLES=4.
module tb_edge_detect_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  edge_detect_multi_if #(.NUM_CH(4)) bus ();

  edge_detect_multi #(
    .NUM_CH(4),
    .SYNC_STAGES(2),
    .DB_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.level, bus.pulse, bus.dir, bus.sticky} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state got=%h expected=0000", {bus.level, bus.pulse, bus.dir, bus.sticky});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_rise();
    logic [3:0] exp;
    bus.sig[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = {(e >= 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0, (e == 6) ? 1'b1 : 1'b0, (e >= 7) ? 1'b1 : 1'b0};
      checks++;
      if ({bus.level[0], bus.pulse[0], bus.dir[0], bus.sticky[0]} !== exp) begin
        failures++;
        $display("FAIL basic_rise edge=%0d lvl/pls/dir/stk=%b expected=%b", e,
                 {bus.level[0], bus.pulse[0], bus.dir[0], bus.sticky[0]}, exp);
      end
      checks++;
      if ({bus.level[3:1], bus.pulse[3:1], bus.sticky[3:1]} !== 9'h000) begin
        failures++;
        $display("FAIL basic_rise_other edge=%0d got=%h expected=000", e,
                 {bus.level[3:1], bus.pulse[3:1], bus.sticky[3:1]});
      end
    end
  endtask

  task automatic test_glitch();
    int n = 0;
    int pe = 0;
    bus.sig[1] = 1'b1;
    tick();
    tick();
    tick();
    bus.sig[1] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if ({bus.level[1], bus.pulse[1]} !== 2'b00) begin
        failures++;
        $display("FAIL glitch_reject cycle=%0d lvl/pls=%b expected=00", e, {bus.level[1], bus.pulse[1]});
      end
    end
    bus.sig[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.pulse[1] === 1'b1) begin
        n++;
        pe = e;
      end
    end
    checks++;
    if (n != 1 || pe != 6 || bus.level[1] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_accept pulses=%0d at_edge=%0d level=%b expected 1 pulse at edge 6 level=1",
               n, pe, bus.level[1]);
    end
  endtask

  task automatic test_fall_only();
    int n = 0;
    logic [2:0] exp;
    bus.mode = 8'hEF;
    bus.sig[2] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (bus.pulse[2] !== 1'b0) n++;
    end
    checks++;
    if (n != 0 || bus.level[2] !== 1'b1 || bus.sticky[2] !== 1'b0) begin
      failures++;
      $display("FAIL fall_only_rise pulses=%0d level=%b sticky=%b expected 0 pulses level=1 sticky=0",
               n, bus.level[2], bus.sticky[2]);
    end
    bus.sig[2] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = {(e == 6) ? 1'b1 : 1'b0, 1'b0, (e >= 7) ? 1'b1 : 1'b0};
      checks++;
      if ({bus.pulse[2], bus.dir[2], bus.sticky[2]} !== exp) begin
        failures++;
        $display("FAIL fall_only_fall edge=%0d pls/dir/stk=%b expected=%b", e,
                 {bus.pulse[2], bus.dir[2], bus.sticky[2]}, exp);
      end
    end
    bus.mode = 8'hFF;
  endtask

  task automatic test_sticky_priority();
    bus.clr_sticky[0] = 1'b1;
    tick();
    bus.clr_sticky[0] = 1'b0;
    checks++;
    if (bus.sticky[0] !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear got=%b expected=0", bus.sticky[0]);
    end
    bus.sig[0] = 1'b0;
    for (int e = 1; e <= 6; e++) tick();
    checks++;
    if ({bus.pulse[0], bus.dir[0], bus.sticky[0]} !== 3'b100) begin
      failures++;
      $display("FAIL sticky_fall_pulse pls/dir/stk=%b expected=100", {bus.pulse[0], bus.dir[0], bus.sticky[0]});
    end
    bus.clr_sticky[0] = 1'b1;
    tick();
    checks++;
    if ({bus.pulse[0], bus.sticky[0]} !== 2'b01) begin
      failures++;
      $display("FAIL sticky_set_wins pls/stk=%b expected=01", {bus.pulse[0], bus.sticky[0]});
    end
    tick();
    checks++;
    if (bus.sticky[0] !== 1'b0) begin
      failures++;
      $display("FAIL sticky_clear_alone got=%b expected=0", bus.sticky[0]);
    end
    bus.clr_sticky[0] = 1'b0;
  endtask

  task automatic test_reset_mid_debounce();
    int n = 0;
    int pe = 0;
    int other = 0;
    logic d = 1'b0;
    bus.sig = 4'b1000;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.level, bus.pulse, bus.dir, bus.sticky} !== 16'h0000) begin
      failures++;
      $display("FAIL mid_debounce_reset got=%h expected=0000", {bus.level, bus.pulse, bus.dir, bus.sticky});
    end
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.pulse[3] === 1'b1) begin
        n++;
        pe = e;
        d = bus.dir[3];
      end
      if (bus.pulse[2:0] !== 3'b000) other++;
    end
    checks++;
    if (n != 1 || pe != 6 || d !== 1'b1 || other != 0) begin
      failures++;
      $display("FAIL post_reset_rise pulses=%0d at_edge=%0d dir=%b stray=%0d expected 1 pulse at edge 6 dir=1 stray=0",
               n, pe, d, other);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    bus.sig = 4'h0;
    for (int e = 1; e <= 10; e++) tick();
    bus.sig = 4'hF;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e == 6) ? 8'hFF : 8'h00;
      checks++;
      if ({bus.pulse, bus.dir} !== exp) begin
        failures++;
        $display("FAIL simul_rise edge=%0d pulse/dir=%h expected=%h", e, {bus.pulse, bus.dir}, exp);
      end
    end
    bus.mode = 8'h00;
    tick();
    bus.mode = 8'hFF;
    #1;
    checks++;
    if (bus.pulse !== 4'h0) begin
      failures++;
      $display("FAIL mode_change_pulse got=%h expected=0", bus.pulse);
    end
    bus.sig = 4'h0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      exp = (e == 6) ? 8'hF0 : 8'h00;
      checks++;
      if ({bus.pulse, bus.dir} !== exp) begin
        failures++;
        $display("FAIL simul_fall edge=%0d pulse/dir=%h expected=%h", e, {bus.pulse, bus.dir}, exp);
      end
    end
  endtask

  initial begin
    bus.sig = 4'h0;
    bus.mode = 8'hFF;
    bus.clr_sticky = 4'h0;
    test_reset();
    test_basic_rise();
    test_glitch();
    test_fall_only();
    test_sticky_priority();
    test_reset_mid_debounce();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
